// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM state encoding
// and the conditional two's-complement negate used for sign handling.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

  // Widest operand the negate helper covers; callers zero-extend, then truncate.
  localparam int DIV_MAX_W = 128;

  function automatic logic [DIV_MAX_W-1:0] div_cond_neg(
    input logic [DIV_MAX_W-1:0] val,
    input logic                 neg
  );
    logic [DIV_MAX_W-1:0] res;
    if (neg) begin
      res = ~val + {{(DIV_MAX_W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_multi_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Partial remainder is always below the divisor, so bit WIDTH of the trial is the borrow.
  always_comb begin
    shifted_s = {partial_rem, dividend_bit};
    trial_s   = shifted_s - {1'b0, divisor};
    if (trial_s[WIDTH]) begin
      rem_next = shifted_s[WIDTH-1:0];
      quot_bit = 1'b0;
    end else begin
      rem_next = trial_s[WIDTH-1:0];
      quot_bit = 1'b1;
    end
  end

endmodule

// File: rtl/div_multi.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per
// cycle, with defined divide-by-zero result and a cancel input.
module div_multi
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               signed_div_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] dividend_r;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quot_r;
  logic             sign_1_r;
  logic             sign_2_r;

  logic             sign_1_s;
  logic             sign_2_s;
  logic [WIDTH-1:0] mag_1_s;
  logic [WIDTH-1:0] mag_2_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] step_rem_s;
  logic             step_quot_s;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .partial_rem (rem_r),
    .dividend_bit(dividend_r[WIDTH-1]),
    .divisor     (divisor_r),
    .rem_next    (step_rem_s),
    .quot_bit    (step_quot_s)
  );

  // Operand magnitudes at accept and sign-corrected results for the fix-up cycle.
  always_comb begin
    sign_1_s   = opdata1_i[WIDTH-1] & signed_div_i;
    sign_2_s   = opdata2_i[WIDTH-1] & signed_div_i;
    mag_1_s    = WIDTH'(div_cond_neg(DIV_MAX_W'(opdata1_i), sign_1_s));
    mag_2_s    = WIDTH'(div_cond_neg(DIV_MAX_W'(opdata2_i), sign_2_s));
    quot_fix_s = WIDTH'(div_cond_neg(DIV_MAX_W'(quot_r), sign_1_r ^ sign_2_r));
    rem_fix_s  = WIDTH'(div_cond_neg(DIV_MAX_W'(rem_r), sign_1_r));
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= DIV_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      dividend_r    <= {WIDTH{1'b0}};
      divisor_r     <= {WIDTH{1'b0}};
      rem_r         <= {WIDTH{1'b0}};
      quot_r        <= {WIDTH{1'b0}};
      sign_1_r      <= 1'b0;
      sign_2_r      <= 1'b0;
      result_o      <= {(2*WIDTH){1'b0}};
      ready_o       <= 1'b0;
      busy_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          result_o      <= {(2*WIDTH){1'b0}};
          ready_o       <= 1'b0;
          busy_o        <= 1'b0;
          div_by_zero_o <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == {WIDTH{1'b0}}) begin
              state_r       <= DIV_DONE;
              result_o      <= {opdata1_i, {WIDTH{1'b1}}};
              ready_o       <= 1'b1;
              div_by_zero_o <= 1'b1;
            end else begin
              state_r    <= DIV_CALC;
              busy_o     <= 1'b1;
              sign_1_r   <= sign_1_s;
              sign_2_r   <= sign_2_s;
              dividend_r <= mag_1_s;
              divisor_r  <= mag_2_s;
              rem_r      <= {WIDTH{1'b0}};
              quot_r     <= {WIDTH{1'b0}};
              cnt_r      <= {CNT_W{1'b0}};
            end
          end
        end
        DIV_CALC: begin
          if (annul_i) begin
            state_r <= DIV_IDLE;
            busy_o  <= 1'b0;
          end else begin
            rem_r      <= step_rem_s;
            quot_r     <= {quot_r[WIDTH-2:0], step_quot_s};
            dividend_r <= {dividend_r[WIDTH-2:0], 1'b0};
            cnt_r      <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
              state_r <= DIV_FIX;
            end
          end
        end
        DIV_FIX: begin
          busy_o <= 1'b0;
          if (annul_i) begin
            state_r <= DIV_IDLE;
          end else begin
            state_r       <= DIV_DONE;
            result_o      <= {rem_fix_s, quot_fix_s};
            ready_o       <= 1'b1;
            div_by_zero_o <= 1'b0;
          end
        end
        DIV_DONE: begin
          // Result is held until the requester drops start_i.
          if (!start_i) begin
            state_r       <= DIV_IDLE;
            result_o      <= {(2*WIDTH){1'b0}};
            ready_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
          end
        end
        default: begin
          state_r       <= DIV_IDLE;
          result_o      <= {(2*WIDTH){1'b0}};
          ready_o       <= 1'b0;
          busy_o        <= 1'b0;
          div_by_zero_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_multi.md
Name: div_multi

Overview:
Parametrised iterative radix-2 restoring divider. It is the successor to the fixed 32-bit execute-stage divider.
- Handles any operand width, signed and unsigned operands, defined divide-by-zero results, and signed overflow (MIN / -1).
- Provides busy and divide-by-zero status outputs.
- Sits beside the ALU in the execute stage. The pipeline holds start_i high and stalls until ready_o.

Parameters:
WIDTH, 32, operand width in bits (>= 4); quotient and remainder are each WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
signed_div_i  input  1  1 = two's-complement operands, 0 = unsigned
start_i  input  1  request; held high by requester until result consumed
annul_i  input  1  cancel the operation in flight
result_o  output  2*WIDTH  {remainder, quotient}
ready_o  output  1  result valid
busy_o  output  1  high in CALC and FIX
div_by_zero_o  output  1  qualifies result_o when ready_o=1: divisor was zero

Behaviour:
- Reset (synchronous, active-high): state=IDLE; result_o=0; ready_o=0; busy_o=0; div_by_zero_o=0. Reset wins over every other input in any state, including mid-CALC.
- The operands and signed_div_i are captured at the accept edge. Later changes to the inputs do not affect the result.
- IDLE:
  - start_i=1 and annul_i=0 accepts the request.
  - Divisor == 0: go to DONE. Set result_o = {opdata1_i, all-ones}, div_by_zero_o=1, ready_o=1 on the accept edge.
  - Divisor != 0:
    - Latch sign_1 = opdata1_i[MSB] & signed_div_i and sign_2 = opdata2_i[MSB] & signed_div_i.
    - Latch the magnitudes: two's-complement negate when the latched sign is 1.
    - Clear the partial remainder, set cnt=0, go to CALC.
  - start_i=0 or annul_i=1: stay in IDLE with ready_o=0 and result_o=0.
- CALC: one quotient bit per cycle, MSB first.
  - Form trial = {partial_rem, next dividend bit} - divisor, computed in WIDTH+1 bits.
  - Borrow: shift in quotient bit 0, keep the shifted remainder. No borrow: take the trial value, shift in 1.
  - cnt increments each cycle. After exactly WIDTH cycles go to FIX.
- FIX (1 cycle):
  - Negate the quotient if sign_1 ^ sign_2.
  - Negate the remainder if sign_1. The remainder sign follows the dividend; a zero remainder stays zero.
  - Go to DONE with ready_o=1, div_by_zero_o=0, result_o loaded.
- Latency (divisor != 0): ready_o is high in the cycle starting WIDTH+1 edges after the accept edge.
- DONE:
  - Hold result_o, ready_o and div_by_zero_o stable while start_i=1.
  - start_i=0: go to IDLE and clear ready_o, result_o and div_by_zero_o on that edge.
  - A new request needs start_i low for at least one edge (back-to-back starts are not accepted).
- annul_i:
  - In CALC or FIX: go to IDLE on that edge. ready_o never asserts and result_o stays 0.
  - Ignored in DONE.
  - In IDLE it blocks acceptance.
- busy_o = (state==CALC or FIX), registered with the state.
- Signed overflow: MIN / -1 gives quotient = MIN and remainder = 0, with no flag. This falls out of the unsigned magnitude path and requires no special case.
- Unsigned mode never negates; MSB-set operands are treated as large positives.

Decomposition:
- Shared package div_pkg:
  - State encoding localparams DIV_IDLE=2'b00, DIV_CALC=2'b01, DIV_FIX=2'b10, DIV_DONE=2'b11.
  - Helper function for the conditional two's-complement negate.
- One sub-module div_step (combinational, parameter WIDTH):
  - Inputs: partial remainder, incoming dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- FSM, counter and sign fix-up stay in div_multi.

Test Plan:
- WIDTH=32, unsigned, 100 / 7 → after 33 cycles ready_o=1, result_o={32'd2, 32'd14}, div_by_zero_o=0; busy_o high for exactly 33 cycles.
- WIDTH=32, signed, -100 / 7 → result_o={32'hFFFFFFFE, 32'hFFFFFFF2}. Also 100 / -7 → {32'd2, 32'hFFFFFFF2}.
- WIDTH=32, signed, 32'h80000000 / 32'hFFFFFFFF → result_o={32'd0, 32'h80000000}. Unsigned same operands → {32'h80000000, 32'd0}.
- WIDTH=32, 5 / 0 → ready_o=1 right after the accept edge, result_o={32'd5, 32'hFFFFFFFF}, div_by_zero_o=1. Drop start_i → all outputs 0 next edge.
- WIDTH=8, unsigned, 255 / 16 → result_o={8'd15, 8'd15} after 9 cycles. Pulse annul_i at CALC cycle 4 of a second divide → IDLE, ready_o never asserts.
- Assert reset at CALC cycle 10 (WIDTH=32) → all outputs 0 next edge. A subsequent 1000 / 10 completes correctly: {32'd0, 32'd100}.
